// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the program counter, drives the instruction ROM,
// and registers the returned word into an IF/ID stage with a valid/ready handshake.
module instruction_fetch_unit #(
    parameter int unsigned          DATA_W     = 32,
    parameter logic [DATA_W-1:0]    RESET_PC   = 32'h0,
    parameter int unsigned          IMEM_WORDS = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [DATA_W-1:0] PC,
    input  logic [DATA_W-1:0] Instruction,
    output logic              IF_Valid,
    input  logic              ID_Ready,
    output logic [DATA_W-1:0] IF_Instruction,
    output logic [DATA_W-1:0] IF_PC,
    input  logic              Branch_Taken,
    input  logic [DATA_W-1:0] Branch_Target,
    output logic              Fetch_Done
);

    localparam int unsigned PC_STEP = 4;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] fetch_pc;
    logic [DATA_W-1:0] pc_nxt;
    logic [DATA_W-1:0] instr_nxt;
    logic [DATA_W-1:0] if_pc_nxt;
    logic              valid_nxt;
    logic              done_nxt;

    logic              accept;
    logic              in_range;
    logic [DATA_W-1:0] target_aligned;
    logic              unused_target_bits;

    // Handshake/range qualifiers and word-aligned redirect address
    assign accept             = !IF_Valid || ID_Ready;
    assign in_range           = (fetch_pc >> 2) < DATA_W'(IMEM_WORDS);
    assign target_aligned     = {Branch_Target[DATA_W-1:2], 2'b00};
    assign unused_target_bits = ^Branch_Target[1:0];

    assign PC = fetch_pc;

    // State and IF/ID register update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            fetch_pc       <= RESET_PC;
            IF_Valid       <= 1'b0;
            IF_Instruction <= '0;
            IF_PC          <= '0;
            Fetch_Done     <= 1'b0;
        end else begin
            state          <= state_nxt;
            fetch_pc       <= pc_nxt;
            IF_Valid       <= valid_nxt;
            IF_Instruction <= instr_nxt;
            IF_PC          <= if_pc_nxt;
            Fetch_Done     <= done_nxt;
        end
    end

    // Next-state: redirect beats capture; capture only while the PC is inside the program
    always_comb begin
        state_nxt = state;
        pc_nxt    = fetch_pc;
        valid_nxt = IF_Valid;
        instr_nxt = IF_Instruction;
        if_pc_nxt = IF_PC;
        done_nxt  = Fetch_Done;

        case (state)
            RUN: begin
                if (Branch_Taken) begin
                    pc_nxt    = target_aligned;
                    valid_nxt = 1'b0;
                end else if (accept && in_range) begin
                    instr_nxt = Instruction;
                    if_pc_nxt = fetch_pc;
                    valid_nxt = 1'b1;
                    pc_nxt    = fetch_pc + DATA_W'(PC_STEP);
                end else if (accept) begin
                    valid_nxt = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                valid_nxt = 1'b0;
                done_nxt  = 1'b1;
                if (Branch_Taken) begin
                    pc_nxt    = target_aligned;
                    done_nxt  = 1'b0;
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus
// randomized stalls/branches checked by a consumed-stream scoreboard.
module tb_instruction_fetch_unit;

    localparam int unsigned NWORDS = 7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        IF_Valid;
    logic        ID_Ready;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PC;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic        Fetch_Done;

    logic [31:0] rom [0:NWORDS-1] = '{32'hF8400281, 32'h8B010022, 32'hD1000333, 32'hB40000E3,
                                      32'h91002294, 32'hF81F4281, 32'h17FFFFFA};
    logic [31:0] garbage;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] end_pc = 32'h0;

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .PC             (PC),
        .Instruction    (Instruction),
        .IF_Valid       (IF_Valid),
        .ID_Ready       (ID_Ready),
        .IF_Instruction (IF_Instruction),
        .IF_PC          (IF_PC),
        .Branch_Taken   (Branch_Taken),
        .Branch_Target  (Branch_Target),
        .Fetch_Done     (Fetch_Done)
    );

    always #5 clk = ~clk;

    // Combinational ROM; out-of-range addresses return junk that must never be captured
    assign Instruction = (PC[31:2] < 30'(NWORDS)) ? rom[PC[4:2]] : garbage;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Expected consumed stream after fetching starts at t: every in-range word in order
    function automatic void build(input logic [31:0] t);
        logic [31:0] a;
        exp_q.delete();
        a = {t[31:2], 2'b00};
        while ((a >> 2) < 32'(NWORDS)) begin
            exp_q.push_back(a);
            a = a + 32'd4;
        end
        end_pc = a;
    endfunction

    // Drive one cycle of inputs, advance past the edge, retarget the scoreboard on a redirect
    task automatic step(input logic br, input logic [31:0] tgt, input logic rdy);
        Branch_Taken  = br;
        Branch_Target = tgt;
        ID_Ready      = rdy;
        garbage       = $urandom;
        @(posedge clk);
        if (br && rst_n) build(tgt);
        #1;
    endtask

    // Monitor: pops the scoreboard on every completed handshake and checks hold/done rules
    logic        prev_stall = 1'b0;
    logic [31:0] prev_pc, prev_instr, prev_ifpc;
    int          idle = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            idle       = 0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_pc", PC, prev_pc);
                check("stall_hold_instr", IF_Instruction, prev_instr);
                check("stall_hold_ifpc", IF_PC, prev_ifpc);
                check("stall_hold_valid", {31'd0, IF_Valid}, 32'd1);
            end
            if (IF_Valid && ID_Ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word_pc", IF_PC, 32'hFFFF_FFFF);
                end else begin
                    logic [31:0] a;
                    a = exp_q.pop_front();
                    check("sb_if_pc", IF_PC, a);
                    check("sb_if_instr", IF_Instruction, rom[a[4:2]]);
                end
            end
            if (Fetch_Done) begin
                check("done_valid_low", {31'd0, IF_Valid}, 32'd0);
                check("done_pc", PC, end_pc);
                check("done_queue_empty", 32'(exp_q.size()), 32'd0);
            end
            if (exp_q.size() == 0 && !Branch_Taken) idle++;
            else idle = 0;
            if (idle >= 2) check("idle_fetch_done", {31'd0, Fetch_Done}, 32'd1);
            prev_stall = IF_Valid && !ID_Ready && !Branch_Taken;
            prev_pc    = PC;
            prev_instr = IF_Instruction;
            prev_ifpc  = IF_PC;
        end
    end

    initial begin
        logic        br, prev_br, rdy;
        logic [31:0] tgt;
        rst_n = 1'b0; Branch_Taken = 1'b0; Branch_Target = '0; ID_Ready = 1'b1; garbage = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_valid", {31'd0, IF_Valid}, 32'd0);
        check("rst_pc", PC, 32'h0);
        check("rst_done", {31'd0, Fetch_Done}, 32'd0);
        check("rst_instr", IF_Instruction, 32'h0);
        check("rst_ifpc", IF_PC, 32'h0);
        #1 rst_n = 1'b1; build(32'h0);
        @(posedge clk); #1;
        check("first_valid", {31'd0, IF_Valid}, 32'd1);
        check("first_instr", IF_Instruction, 32'hF8400281);
        check("first_ifpc", IF_PC, 32'h0);
        check("first_pc", PC, 32'h4);

        // Three stall cycles hold the first word
        repeat (3) begin
            step(1'b0, 32'h0, 1'b0);
            check("stall_valid", {31'd0, IF_Valid}, 32'd1);
            check("stall_instr", IF_Instruction, 32'hF8400281);
            check("stall_pc", PC, 32'h4);
        end
        step(1'b0, 32'h0, 1'b1);
        check("after_stall_instr", IF_Instruction, 32'h8B010022);
        check("after_stall_ifpc", IF_PC, 32'h4);
        repeat (3) step(1'b0, 32'h0, 1'b1);
        check("pre_branch_ifpc", IF_PC, 32'h10);

        // Redirect to a misaligned target
        step(1'b1, 32'h6, 1'b1);
        check("branch_flush_valid", {31'd0, IF_Valid}, 32'd0);
        check("branch_pc", PC, 32'h4);
        step(1'b0, 32'h0, 1'b1);
        check("branch_instr", IF_Instruction, 32'h8B010022);
        check("branch_ifpc", IF_PC, 32'h4);

        // Run off the end of the program
        for (int i = 0; i < 20 && !(IF_Valid && IF_PC == 32'h18); i++) step(1'b0, 32'h0, 1'b1);
        check("last_ifpc", IF_PC, 32'h18);
        check("last_instr", IF_Instruction, 32'h17FFFFFA);
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 32'h0, 1'b1);
            check("end_pc", PC, 32'h1C);
            check("end_done", {31'd0, Fetch_Done}, 32'd1);
            check("end_valid", {31'd0, IF_Valid}, 32'd0);
        end

        // Restart from DONE
        step(1'b1, 32'h8, 1'b1);
        check("restart_done", {31'd0, Fetch_Done}, 32'd0);
        check("restart_pc", PC, 32'h8);
        step(1'b0, 32'h0, 1'b1);
        check("restart_instr", IF_Instruction, 32'hD1000333);
        check("restart_ifpc", IF_PC, 32'h8);

        // Asynchronous reset in the middle of a stall
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        @(negedge clk); #2 rst_n = 1'b0; #1;
        check("async_rst_valid", {31'd0, IF_Valid}, 32'd0);
        check("async_rst_pc", PC, 32'h0);
        check("async_rst_done", {31'd0, Fetch_Done}, 32'd0);
        @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1; ID_Ready = 1'b1; Branch_Taken = 1'b0; build(32'h0);
        @(posedge clk); #1;
        check("rerun_instr", IF_Instruction, 32'hF8400281);
        check("rerun_ifpc", IF_PC, 32'h0);

        // Random stalls and redirects, including out-of-range targets
        prev_br = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            br  = !prev_br && ($urandom_range(0, 19) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 35));
            rdy = ($urandom_range(0, 3) != 0);
            step(br, tgt, rdy);
            prev_br = br;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
